alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU datapath (orGate_N, andGate_N, adder and the other N-bit units selected by the ALU mux).
- Captures the ALU result with its carry and overflow, derives the N and Z flags, and presents the result to writeback over a valid/ready handshake with a 2-entry skid buffer.
- Maintains the architectural NZCV flag register, updated in consumption order.

Parameters:
- N, 4, datapath width; must match the ALU width.
- DEST_W, 4, width of the destination register tag carried with each result.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept; registered.
- in_result  in  N  ALU result.
- in_carry  in  1  ALU carry-out.
- in_overflow  in  1  ALU signed overflow.
- in_set_flags  in  1  entry updates NZCV when consumed.
- in_dest  in  DEST_W  destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts.
- out_result  out  N  head result.
- out_dest  out  DEST_W  head destination tag.
- out_nzcv  out  4  head entry's computed flags {N,Z,C,V}.
- flags  out  4  architectural NZCV register {N,Z,C,V}.

Behaviour:
- Handshakes:
  - Accept on a clk edge with in_valid && in_ready.
  - Deliver on a clk edge with out_valid && out_ready.
- Storage: two entries, main (head, drives out_*) and skid. Each entry holds result, dest, nzcv and set_flags.
- Flag computation at capture:
  - N = in_result[N-1].
  - Z = (in_result == 0).
  - C = in_carry.
  - V = in_overflow.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE; the entry loads main.
  - ONE + accept, no deliver -> FULL; the entry loads skid.
  - ONE + deliver, no accept -> EMPTY.
  - ONE + accept + deliver -> ONE; main is replaced by the new entry with no bubble.
  - FULL + deliver -> ONE; skid moves to main. in_ready=1 from the next cycle.
  - FULL ignores in_valid (in_ready=0).
- Latency: an entry accepted at edge k is visible on out_* after edge k (1 cycle).
- Throughput: 1 result/cycle while out_ready=1.
- out_* hold stable while out_valid && !out_ready.
- out_result, out_dest and out_nzcv are 0 while EMPTY.
- flags update:
  - flags <= head nzcv on the deliver edge, only if the head entry's set_flags=1.
  - Otherwise flags hold.
  - The update is never applied at accept time, so flags follow consumption order.
- in_valid && !in_ready: the input is not captured. The ALU must hold its inputs stable until accepted.
- Reset (rst=0 at an edge, including mid-transfer):
  - Both entries are discarded and the state goes to EMPTY.
  - out_valid=0, in_ready=1.
  - out_result, out_dest and out_nzcv = 0.
  - flags = 4'b0000.
  - Accepts and delivers on a reset edge are ignored.
- Widths: no arithmetic beyond the Z compare. All fields are stored at their port widths.

Decomposition:
- alu_pkg holds:
  - typedef nzcv_t (packed struct n,z,c,v).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef stage_state_t {EMPTY, ONE, FULL}.
  - function calc_nzcv(result, carry, overflow).
- No sub-module: the entry storage is two instances of one packed entry struct (entry_t, also in alu_pkg) inside alu_result_stage.

Test Plan:
- Reset, then hold out_ready=1 and in_valid=1 with result 4'b0111 (C=0,V=0,set_flags=1):
  - out_valid rises 1 cycle after accept.
  - out_result=4'b0111, out_nzcv=4'b0000.
  - flags=4'b0000.
- Result 4'b1111 (set_flags=1, C=1), delivered:
  - out_nzcv=4'b1010.
  - flags becomes 4'b1010 on the deliver edge, not before.
- out_ready=0, accept 4'b0001 then 4'b0000:
  - in_ready=0 after the second accept.
  - A third in_valid is not captured.
  - Release out_ready: 4'b0001 then 4'b0000 (out_nzcv=4'b0100) delivered in order, in_ready=1 after the first deliver.
- Streaming: in_valid=1 and out_ready=1 each cycle for 5 results (0,1,15,7|8=15,15):
  - Delivered back-to-back with no bubble and no drop.
  - Z set only on the first.
- Entry with set_flags=0 and result 4'b0000 delivered after flags=4'b1010: flags stays 4'b1010.
- State FULL, assert rst=0 for one edge:
  - Next cycle out_valid=0, in_ready=1, flags=4'b0000.
  - No stale entry delivered afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and helpers for the ALU result stage.
//               - nzcv_t        : packed {n,z,c,v} flag group
//               - FLAG_*        : bit positions of each flag in a 4-bit NZCV
//               - stage_state_t : occupancy of the 2-entry result buffer
//               - entry_t       : one buffered ALU result with its flags
//               - calc_nzcv     : derive NZCV from an ALU result
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Datapath widths shared by the ALU and its result stage. The stage's
  // N / DEST_W parameters default to these and must stay equal to them,
  // since entry_t stores every field at exactly these widths.
  localparam int ALU_N      = 4;
  localparam int ALU_DEST_W = 4;

  // Bit positions within a 4-bit {N,Z,C,V} vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [ALU_N-1:0]      result;
    logic [ALU_DEST_W-1:0] dest;
    nzcv_t                 nzcv;
    logic                  set_flags;
  } entry_t;

  // N and Z come from the result itself; C and V are passed through from
  // the ALU because only it knows the operands.
  function automatic nzcv_t calc_nzcv(input logic [ALU_N-1:0] result,
                                      input logic             carry,
                                      input logic             overflow);
    nzcv_t f;
    f.n = result[ALU_N-1];
    f.z = (result == '0);
    f.c = carry;
    f.v = overflow;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered output stage behind the ALU mux. Captures result,
//               carry and overflow, derives N/Z, and hands the result to
//               writeback through a valid/ready handshake backed by a
//               2-entry (main + skid) buffer. Keeps the architectural NZCV
//               register, updated when a flag-setting entry is delivered.
// Ports       :
//   clk          in   1       clock, rising edge
//   rst          in   1       synchronous reset, active low
//   in_valid     in   1       ALU result valid
//   in_ready     out  1       stage can accept (registered)
//   in_result    in   N       ALU result
//   in_carry     in   1       ALU carry-out
//   in_overflow  in   1       ALU signed overflow
//   in_set_flags in   1       entry updates NZCV when consumed
//   in_dest      in   DEST_W  destination tag
//   out_valid    out  1       head entry available
//   out_ready    in   1       writeback accepts
//   out_result   out  N       head result
//   out_dest     out  DEST_W  head destination tag
//   out_nzcv     out  4       head entry flags {N,Z,C,V}
//   flags        out  4       architectural NZCV {N,Z,C,V}
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N      = alu_pkg::ALU_N,
  parameter int DEST_W = alu_pkg::ALU_DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_result,
  input  logic              in_carry,
  input  logic              in_overflow,
  input  logic              in_set_flags,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic [3:0]        out_nzcv,
  output logic [3:0]        flags
);

  stage_state_t state_q, state_d;
  entry_t       main_q,  main_d;
  entry_t       skid_q,  skid_d;
  nzcv_t        flags_q, flags_d;
  logic         in_ready_q, in_ready_d;

  entry_t       new_entry;
  logic         accept;
  logic         deliver;

  // Incoming entry, with flags computed at capture time.
  always_comb begin
    new_entry           = '0;
    new_entry.result    = in_result;
    new_entry.dest      = in_dest;
    new_entry.nzcv      = calc_nzcv(in_result, in_carry, in_overflow);
    new_entry.set_flags = in_set_flags;
  end

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign deliver   = out_valid && out_ready;

  // Next-state, entry movement and flag update.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    flags_d = flags_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          // Replace head in the same cycle: no bubble.
          main_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = FULL;
        end else if (deliver) begin
          // Clearing main keeps out_* at zero while empty.
          main_d  = '0;
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so accept cannot occur.
        if (deliver) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase

    // Flags follow delivery order, never acceptance order.
    if (deliver && main_q.set_flags) begin
      flags_d = main_q.nzcv;
    end

    // Registered ready: high unless the buffer will be full next cycle.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      flags_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      flags_q    <= flags_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_result = main_q.result;
  assign out_dest   = main_q.dest;
  assign out_nzcv   = main_q.nzcv;
  assign flags      = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Directed self-checking bench for alu_result_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic       in_carry;
  logic       in_overflow;
  logic       in_set_flags;
  logic [3:0] in_dest;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_dest;
  logic [3:0] out_nzcv;
  logic [3:0] flags;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.N(4), .DEST_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_overflow  (in_overflow),
    .in_set_flags (in_set_flags),
    .in_dest      (in_dest),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_dest     (out_dest),
    .out_nzcv     (out_nzcv),
    .flags        (flags)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] r, input logic c,
                       input logic ov, input logic sf, input logic [3:0] d);
    in_valid     = v;
    in_result    = r;
    in_carry     = c;
    in_overflow  = ov;
    in_set_flags = sf;
    in_dest      = d;
  endtask

  logic [3:0] s_val  [5];
  logic [3:0] s_nzcv [5];

  initial begin
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();
    step();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_nzcv", out_nzcv, 0);
    chk("rst_flags", flags, 0);

    rst = 1'b1;
    step();

    // Single result 0111, C=0 V=0, set_flags
    out_ready = 1'b1;
    drive(1'b1, 4'b0111, 1'b0, 1'b0, 1'b1, 4'h3);
    chk("pre_accept_valid", out_valid, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_result", out_result, 4'b0111);
    chk("t1_out_dest", out_dest, 4'h3);
    chk("t1_out_nzcv", out_nzcv, 4'b0000);
    chk("t1_flags", flags, 4'b0000);

    // 1111 with carry: delivers 0111 and captures 1111 in one edge
    drive(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 4'h5);
    step();
    chk("t2_out_result", out_result, 4'b1111);
    chk("t2_out_nzcv", out_nzcv, 4'b1010);
    chk("t2_flags_before", flags, 4'b0000);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();
    chk("t2_flags_after", flags, 4'b1010);
    chk("t2_empty_valid", out_valid, 0);
    chk("t2_empty_result", out_result, 0);
    chk("t2_empty_nzcv", out_nzcv, 0);

    // Backpressure: fill both entries, third input not captured
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'h1);
    step();
    chk("t3_ready_one", in_ready, 1);
    chk("t3_head_a", out_result, 4'b0001);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h2);
    step();
    chk("t3_ready_full", in_ready, 0);
    drive(1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 4'h7);
    step();
    chk("t3_hold_result", out_result, 4'b0001);
    chk("t3_hold_dest", out_dest, 4'h1);
    chk("t3_hold_ready", in_ready, 0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    out_ready = 1'b1;
    step();
    chk("t3_second_result", out_result, 4'b0000);
    chk("t3_second_dest", out_dest, 4'h2);
    chk("t3_second_nzcv", out_nzcv, 4'b0100);
    chk("t3_ready_after", in_ready, 1);
    chk("t3_flags_hold1", flags, 4'b1010);
    step();
    chk("t3_no_third", out_valid, 0);
    chk("t3_flags_sf0", flags, 4'b1010);

    // Streaming: one result per cycle, no bubbles
    s_val[0] = 4'd0;  s_nzcv[0] = 4'b0100;
    s_val[1] = 4'd1;  s_nzcv[1] = 4'b0000;
    s_val[2] = 4'd15; s_nzcv[2] = 4'b1000;
    s_val[3] = 4'd15; s_nzcv[3] = 4'b1000;
    s_val[4] = 4'd15; s_nzcv[4] = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, s_val[i], 1'b0, 1'b0, 1'b0, 4'(i));
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_result", out_result, s_val[i]);
      chk("stream_dest", out_dest, i);
      chk("stream_nzcv", out_nzcv, s_nzcv[i]);
      chk("stream_ready", in_ready, 1);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();
    chk("stream_drained", out_valid, 0);
    chk("stream_flags", flags, 4'b1010);

    // Reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 4'b0011, 1'b0, 1'b1, 1'b1, 4'h8);
    step();
    drive(1'b1, 4'b0101, 1'b1, 1'b0, 1'b1, 4'h9);
    step();
    chk("full_before_rst", in_ready, 0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    out_ready = 1'b1;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_flags", flags, 4'b0000);
    chk("rst_mid_result", out_result, 0);
    step();
    chk("rst_no_stale", out_valid, 0);
    chk("rst_flags_stay", flags, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
